// File: rtl/shared_reg_arbiter_pkg.sv
// rtl/shared_reg_arbiter_pkg.sv - FSM state type, default sizes and width helper for shared_reg_arbiter
package shared_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int DEF_N        = 4;
  localparam int DEF_W        = 8;
  localparam int DEF_MAX_LOCK = 4;

  // Never returns 0 so a one-entry range still gets a real 1-bit vector
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// rtl/shared_reg_arbiter_if.sv - requester/arbiter bus; lock hints exist only with SHARED_REG_ARBITER_LOCK_EN
interface shared_reg_arbiter_if
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
);

  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
`ifdef SHARED_REG_ARBITER_LOCK_EN
  logic [N-1:0]   lock;
`endif
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic           q_valid;
  logic           busy;

`ifdef SHARED_REG_ARBITER_LOCK_EN
  modport master (output req, wdata, lock, input gnt, ack, q, q_valid, busy);
  modport slave  (input req, wdata, lock, output gnt, ack, q, q_valid, busy);
`else
  modport master (output req, wdata, input gnt, ack, q, q_valid, busy);
  modport slave  (input req, wdata, output gnt, ack, q, q_valid, busy);
`endif

endinterface

// File: rtl/shared_reg_arbiter_rr_priority_pick.sv
// rtl/shared_reg_arbiter_rr_priority_pick.sv - combinational round-robin pick starting one past ptr
module rr_priority_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int PW = clog2_min1(DEF_N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] index
);

  logic [PW-1:0] cand;

  // Walk farthest-to-nearest so the requester closest after ptr overwrites last
  always_comb begin
    pick  = '0;
    index = '0;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = PW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        pick       = '0;
        pick[cand] = 1'b1;
        index      = cand;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin arbiter and sole writer of the shared register
// Burst lock (lock port, lock_cnt, MAX_LOCK) is built only with SHARED_REG_ARBITER_LOCK_EN.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
`ifdef SHARED_REG_ARBITER_LOCK_EN
  ,
  parameter int MAX_LOCK = DEF_MAX_LOCK
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  shared_reg_arbiter_if.slave  bus
);

  localparam int PW = clog2_min1(N);

  state_t        state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [W-1:0]  q_q, q_d;
  logic          q_valid_q, q_valid_d;

  logic [N-1:0]  pick;
  logic [PW-1:0] pick_index;
  logic [W-1:0]  owner_data;

`ifdef SHARED_REG_ARBITER_LOCK_EN
  localparam int LW = clog2_min1(MAX_LOCK);
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
`endif

  rr_priority_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .pick  (pick),
    .index (pick_index)
  );

  assign owner_data = bus.wdata[owner_q*W +: W];

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    q_d       = q_q;
    q_valid_d = q_valid_q;
`ifdef SHARED_REG_ARBITER_LOCK_EN
    lock_cnt_d = lock_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef SHARED_REG_ARBITER_LOCK_EN
        lock_cnt_d = '0;
`endif
        if (|bus.req) begin
          owner_d = pick_index;
          gnt_d   = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // ptr only advances on a completed write, so a withdrawn owner keeps its turn
        if (bus.req[owner_q]) begin
          q_d            = owner_data;
          q_valid_d      = 1'b1;
          ack_d[owner_q] = 1'b1;
          ptr_d          = owner_q;
          state_d        = WRITE;
        end else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      WRITE: begin
`ifdef SHARED_REG_ARBITER_LOCK_EN
        if (bus.lock[owner_q] && bus.req[owner_q] &&
            (lock_cnt_q < LW'(MAX_LOCK - 1))) begin
          lock_cnt_d = lock_cnt_q + LW'(1);
          state_d    = GRANT;
        end else begin
          lock_cnt_d = '0;
          gnt_d      = '0;
          state_d    = IDLE;
        end
`else
        gnt_d   = '0;
        state_d = IDLE;
`endif
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= PW'(N - 1);
      gnt_q     <= '0;
      ack_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
`ifdef SHARED_REG_ARBITER_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
`ifdef SHARED_REG_ARBITER_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ack     = ack_q;
  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - vector table plus ack scoreboard for shared_reg_arbiter (SHARED_REG_ARBITER_LOCK_EN adds the burst test)
module tb_shared_reg_arbiter;
  import shared_reg_arbiter_pkg::*;

  localparam int N = DEF_N;
  localparam int W = DEF_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  shared_reg_arbiter_if #(.N(N), .W(W)) bus ();

  shared_reg_arbiter #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } exp_t;

  typedef struct {
    logic [N-1:0] req;
    int           lane;
    logic [W-1:0] data;
    logic [N-1:0] exp_gnt;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[4];
  int   order[5];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_lane(input int i, input logic [W-1:0] d);
    bus.wdata[i*W +: W] = d;
  endtask

  task automatic expect_write(input int i, input logic [W-1:0] d);
    exp_t e;
    e.idx  = i;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    tick(1);
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst && (bus.ack != '0)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_ack", 32'(bus.ack), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_ack", 32'(bus.ack), 32'(1) << e.idx);
        check("sb_q", 32'(bus.q), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{req: 4'b0100, lane: 2, data: 8'hA5, exp_gnt: 4'b0100};
    vecs[1] = '{req: 4'b0001, lane: 0, data: 8'h3C, exp_gnt: 4'b0001};
    vecs[2] = '{req: 4'b1000, lane: 3, data: 8'hFF, exp_gnt: 4'b1000};
    vecs[3] = '{req: 4'b0010, lane: 1, data: 8'h81, exp_gnt: 4'b0010};
    order   = '{0, 1, 2, 3, 0};

    bus.req   = '0;
    bus.wdata = '0;
`ifdef SHARED_REG_ARBITER_LOCK_EN
    bus.lock  = '0;
`endif
    #2 rst = 1'b0;
    tick(2);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_q", 32'(bus.q), 32'd0);
    check("rst_q_valid", 32'(bus.q_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    tick(1);

    // single requesters: grant after 1 edge, ack after 2, idle after 3
    for (int v = 0; v < 4; v++) begin
      bus.req = vecs[v].req;
      set_lane(vecs[v].lane, vecs[v].data);
      expect_write(vecs[v].lane, vecs[v].data);
      tick(1);
      check("vec_gnt_c1", 32'(bus.gnt), 32'(vecs[v].exp_gnt));
      check("vec_busy_c1", 32'(bus.busy), 32'd1);
      check("vec_ack_c1", 32'(bus.ack), 32'd0);
      tick(1);
      check("vec_q_valid_c2", 32'(bus.q_valid), 32'd1);
      bus.req = '0;
      tick(1);
      check("vec_gnt_c3", 32'(bus.gnt), 32'd0);
      check("vec_ack_c3", 32'(bus.ack), 32'd0);
      check("vec_busy_c3", 32'(bus.busy), 32'd0);
      check("vec_q_c3", 32'(bus.q), 32'(vecs[v].data));
    end
    check("vec_drain", 32'(sb_q.size()), 32'd0);

    // full contention from reset: 0,1,2,3 then wrap to 0
    do_reset();
    for (int i = 0; i < N; i++) set_lane(i, W'(8'h11 * (i + 1)));
    for (int g = 0; g < 5; g++) expect_write(order[g], W'(8'h11 * (order[g] + 1)));
    bus.req = '1;
    for (int g = 0; g < 5; g++) begin
      tick(1);
      check("rr_gnt", 32'(bus.gnt), 32'(1) << order[g]);
      tick(2);
    end
    bus.req = '0;
    check("rr_drain", 32'(sb_q.size()), 32'd0);

    // withdrawal during GRANT: no write, ptr keeps requester 1 ahead of 2
    tick(1);
    bus.req = 4'b0010;
    tick(1);
    check("wd_gnt", 32'(bus.gnt), 32'b0010);
    bus.req = '0;
    tick(1);
    check("wd_gnt_drop", 32'(bus.gnt), 32'd0);
    check("wd_ack", 32'(bus.ack), 32'd0);
    check("wd_q_kept", 32'(bus.q), 32'h11);
    check("wd_busy", 32'(bus.busy), 32'd0);
    set_lane(1, 8'h5A);
    set_lane(2, 8'h6B);
    expect_write(1, 8'h5A);
    expect_write(2, 8'h6B);
    bus.req = 4'b0110;
    tick(1);
    check("wd_regrant", 32'(bus.gnt), 32'b0010);
    tick(5);
    bus.req = '0;
    check("wd_drain", 32'(sb_q.size()), 32'd0);

    // async reset between edges while in GRANT
    for (int i = 0; i < N; i++) set_lane(i, W'(8'hC0 + i));
    bus.req = '1;
    tick(1);
    check("ar_gnt_before", 32'(bus.gnt), 32'b1000);
    #2 rst = 1'b0;
    #1;
    check("ar_gnt", 32'(bus.gnt), 32'd0);
    check("ar_ack", 32'(bus.ack), 32'd0);
    check("ar_q", 32'(bus.q), 32'd0);
    check("ar_q_valid", 32'(bus.q_valid), 32'd0);
    check("ar_busy", 32'(bus.busy), 32'd0);
    tick(1);
    rst = 1'b1;
    expect_write(0, 8'hC0);
    tick(1);
    check("ar_first_gnt", 32'(bus.gnt), 32'b0001);
    tick(2);
    bus.req = '0;
    check("ar_drain", 32'(sb_q.size()), 32'd0);

`ifdef SHARED_REG_ARBITER_LOCK_EN
    // burst: park ptr at 2, then locked requester 3 takes four writes 2 cycles apart
    do_reset();
    set_lane(2, 8'h22);
    expect_write(2, 8'h22);
    bus.req = 4'b0100;
    tick(3);
    bus.req = '0;
    tick(1);
    set_lane(3, 8'h3C);
    set_lane(0, 8'h0F);
    for (int k = 0; k < 4; k++) expect_write(3, 8'h3C);
    expect_write(0, 8'h0F);
    bus.lock = 4'b1000;
    bus.req  = 4'b1001;
    tick(1);
    check("lk_gnt", 32'(bus.gnt), 32'b1000);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("lk_ack", 32'(bus.ack), 32'b1000);
      tick(1);
      if (k < 3) check("lk_hold", 32'(bus.gnt), 32'b1000);
      else check("lk_release", 32'(bus.gnt), 32'd0);
    end
    tick(1);
    check("lk_next_gnt", 32'(bus.gnt), 32'b0001);
    tick(2);
    bus.req  = '0;
    bus.lock = '0;
    check("lk_drain", 32'(sb_q.size()), 32'd0);
`endif

    tick(2);
    check("final_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
